// File: rtl/backbone_pkg.sv
// Shared definitions for the backbone pipeline: FSM encoding and width helpers.
package backbone_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StCollect = 2'b01,
    StDone    = 2'b10
  } state_e;

  function automatic int unsigned j_width(input int unsigned j);
    return $clog2(j) + 1;
  endfunction

  function automatic int unsigned sum_width(input int unsigned dw, input int unsigned j);
    return dw + $clog2(j);
  endfunction

endpackage

// File: rtl/backbone_j_maxtrack.sv
// Running maximum and its index over one frame; the first element always loads.
module backbone_j_maxtrack #(
  parameter int unsigned DATAWIDTH = 32,
  parameter int unsigned IDX_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 load,
  input  logic [IDX_WIDTH-1:0] idx,
  input  logic [DATAWIDTH-1:0] data,
  output logic [DATAWIDTH-1:0] max_val,
  output logic [IDX_WIDTH-1:0] max_idx
);

  logic [DATAWIDTH-1:0] max_q;
  logic [IDX_WIDTH-1:0] idx_q;

  // Strict greater-than so ties keep the lowest index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q <= '0;
      idx_q <= '0;
    end else if (clear) begin
      max_q <= '0;
      idx_q <= '0;
    end else if (load && ((idx == '0) || (data > max_q))) begin
      max_q <= data;
      idx_q <= idx;
    end
  end

  assign max_val = max_q;
  assign max_idx = idx_q;

endmodule

// File: rtl/backbone_j_collect.sv
// Collects J-1 serial backbone words into a packed vector with a running sum.
// Max/argmax tracking is built only when BACKBONE_J_ARGMAX_EN is defined.
module backbone_j_collect
  import backbone_pkg::*;
#(
  parameter int unsigned J         = 14,
  parameter int unsigned DATAWIDTH = 32,
  localparam int unsigned J_WIDTH   = j_width(J),
  localparam int unsigned SUM_WIDTH = sum_width(DATAWIDTH, J)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         backbone_J_tvalid,
  input  logic [DATAWIDTH-1:0]         backbone_J,
  output logic                         vec_tvalid,
  input  logic                         vec_tready,
  output logic [(J-1)*DATAWIDTH-1:0]   vec_tdata,
  output logic [SUM_WIDTH-1:0]         vec_sum,
  output logic [DATAWIDTH-1:0]         vec_max,
  output logic [J_WIDTH-1:0]           vec_argmax,
  output logic                         overrun
);

  state_e                       state_q;
  logic [J_WIDTH-1:0]           cnt_q;
  logic [SUM_WIDTH-1:0]         sum_q;
  logic                         valid_q;
  logic                         overrun_q;
  logic [(J-1)*DATAWIDTH-1:0]   data_q;
  logic                         capture;
  logic                         last;

  // start wins over a coincident element, so that element is never captured.
  assign capture = (state_q == StCollect) && backbone_J_tvalid && !start;
  assign last    = (cnt_q == J_WIDTH'(J - 2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      sum_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else if (start) begin
      state_q   <= StCollect;
      cnt_q     <= '0;
      sum_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= backbone_J_tvalid;
    end else begin
      case (state_q)
        StIdle: begin
          if (backbone_J_tvalid) overrun_q <= 1'b1;
        end
        StCollect: begin
          if (capture) begin
            cnt_q <= cnt_q + J_WIDTH'(1);
            sum_q <= sum_q + SUM_WIDTH'(backbone_J);
            if (last) begin
              state_q <= StDone;
              valid_q <= 1'b1;
            end
          end
        end
        StDone: begin
          if (backbone_J_tvalid) overrun_q <= 1'b1;
          if (valid_q && vec_tready) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      for (int k = 0; k < int'(J) - 1; k++) begin
        if (capture && (cnt_q == J_WIDTH'(k))) begin
          data_q[k*DATAWIDTH +: DATAWIDTH] <= backbone_J;
        end
      end
    end
  end

  assign vec_tvalid = valid_q;
  assign vec_tdata  = data_q;
  assign vec_sum    = sum_q;
  assign overrun    = overrun_q;

`ifdef BACKBONE_J_ARGMAX_EN
  backbone_j_maxtrack #(
    .DATAWIDTH (DATAWIDTH),
    .IDX_WIDTH (J_WIDTH)
  ) u_maxtrack (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (start),
    .load    (capture),
    .idx     (cnt_q),
    .data    (backbone_J),
    .max_val (vec_max),
    .max_idx (vec_argmax)
  );
`else
  assign vec_max    = '0;
  assign vec_argmax = '0;
`endif

endmodule

// File: tb/tb_backbone_j_collect.sv
// Scoreboard bench for backbone_j_collect: stimulus pushes expected frames, a monitor pops them.
module tb_backbone_j_collect;

  localparam int N  = 13;
  localparam int DW = 32;
  localparam int JW = 5;
  localparam int SW = 36;

  typedef logic [N*DW-1:0] wide_t;

  typedef struct {
    wide_t          data;
    logic [SW-1:0]  sum;
    logic [DW-1:0]  max;
    logic [JW-1:0]  argmax;
  } exp_t;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic            backbone_J_tvalid;
  logic [DW-1:0]   backbone_J;
  logic            vec_tvalid;
  logic            vec_tready;
  wide_t           vec_tdata;
  logic [SW-1:0]   vec_sum;
  logic [DW-1:0]   vec_max;
  logic [JW-1:0]   vec_argmax;
  logic            overrun;

  backbone_j_collect dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .backbone_J_tvalid (backbone_J_tvalid),
    .backbone_J        (backbone_J),
    .vec_tvalid        (vec_tvalid),
    .vec_tready        (vec_tready),
    .vec_tdata         (vec_tdata),
    .vec_sum           (vec_sum),
    .vec_max           (vec_max),
    .vec_argmax        (vec_argmax),
    .overrun           (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_pass   = 0;
  logic        chk_low  = 1'b0;
  logic [31:0] fr [N];

  task automatic check(input string name, input wide_t act, input wide_t exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic wide_t pack(input logic [31:0] e [N]);
    wide_t r;
    for (int k = 0; k < N; k++) r[k*DW +: DW] = e[k];
    return r;
  endfunction

  task automatic push_frame(input logic [31:0] e [N], input logic [SW-1:0] sum,
                            input logic [DW-1:0] mx, input logic [JW-1:0] am);
    exp_t x;
    x.data = pack(e);
    x.sum  = sum;
`ifdef BACKBONE_J_ARGMAX_EN
    x.max    = mx;
    x.argmax = am;
`else
    x.max    = (mx == '0) ? mx : '0;
    x.argmax = (am == '0) ? am : '0;
`endif
    exp_q.push_back(x);
  endtask

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] e [N]);
    for (int k = 0; k < N; k++) begin
      @(posedge clk); #1;
      backbone_J_tvalid = 1'b1;
      backbone_J        = e[k];
      if (k == N - 1) begin
        @(negedge clk);
        check("tvalid_early", wide_t'(vec_tvalid), wide_t'(0));
      end
    end
    @(posedge clk); #1;
    backbone_J_tvalid = 1'b0;
    backbone_J        = '0;
    @(negedge clk);
    check("tvalid_rise", wide_t'(vec_tvalid), wide_t'(1));
  endtask

  task automatic wait_drain();
    int i;
    for (i = 0; i < 20; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain_timeout: got %0d pending frames expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  // Monitor: compares each frame at the sample point before its handshake edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk_low = 1'b0;
    end else begin
      if (chk_low) begin
        check("tvalid_one_cycle", wide_t'(vec_tvalid), wide_t'(0));
        chk_low = 1'b0;
      end
      if (vec_tvalid && vec_tready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_frame: got sum %0h expected no frame", vec_sum);
        end else begin
          mon_e = exp_q.pop_front();
          check("frame_data", vec_tdata, mon_e.data);
          check("frame_sum", wide_t'(vec_sum), wide_t'(mon_e.sum));
          check("frame_max", wide_t'(vec_max), wide_t'(mon_e.max));
          check("frame_argmax", wide_t'(vec_argmax), wide_t'(mon_e.argmax));
          chk_low = 1'b1;
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; backbone_J_tvalid = 1'b0; backbone_J = '0; vec_tready = 1'b1;
    #12;
    check("rst_tvalid", wide_t'(vec_tvalid), wide_t'(0));
    check("rst_tdata", vec_tdata, wide_t'(0));
    check("rst_sum", wide_t'(vec_sum), wide_t'(0));
    check("rst_overrun", wide_t'(overrun), wide_t'(0));
    check("rst_max", wide_t'(vec_max), wide_t'(0));
    check("rst_argmax", wide_t'(vec_argmax), wide_t'(0));
    @(posedge clk); #1 rst_n = 1'b1;

    // Elements 1..13, sum 91.
    for (int k = 0; k < N; k++) fr[k] = 32'(k + 1);
    do_start();
    push_frame(fr, 36'd91, 32'd13, 5'd12);
    send_frame(fr);
    wait_drain();

    // All ones: 13 * 0xFFFFFFFF.
    for (int k = 0; k < N; k++) fr[k] = 32'hFFFF_FFFF;
    do_start();
    push_frame(fr, 36'hC_FFFF_FFF3, 32'hFFFF_FFFF, 5'd0);
    send_frame(fr);
    wait_drain();

    // Tie on the maximum keeps the lower index.
    fr = '{32'd5, 32'd9, 32'd9, 32'd2, 32'd3, 32'd4, 32'd1, 32'd0, 32'd8, 32'd7, 32'd6,
           32'd5, 32'd2};
    do_start();
    push_frame(fr, 36'd61, 32'd9, 5'd1);
    send_frame(fr);
    wait_drain();

    // Element while idle is dropped and flags overrun.
    @(posedge clk); #1 backbone_J_tvalid = 1'b1; backbone_J = 32'd123;
    @(posedge clk); #1 backbone_J_tvalid = 1'b0; backbone_J = '0;
    @(negedge clk);
    check("idle_overrun", wide_t'(overrun), wide_t'(1));
    check("idle_tvalid", wide_t'(vec_tvalid), wide_t'(0));
    check("idle_sum_kept", wide_t'(vec_sum), wide_t'(61));
    check("idle_data_kept", vec_tdata, pack(fr));
    do_start();
    @(negedge clk);
    check("start_clears_overrun", wide_t'(overrun), wide_t'(0));

    // Backpressure: frame held for 10 cycles, a 14th element arrives meanwhile.
    for (int k = 0; k < N; k++) fr[k] = 32'(2 * (k + 1));
    vec_tready = 1'b0;
    push_frame(fr, 36'd182, 32'd26, 5'd12);
    send_frame(fr);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      backbone_J_tvalid = (i == 4);
      backbone_J        = (i == 4) ? 32'd999 : 32'd0;
    end
    @(negedge clk);
    check("hold_tvalid", wide_t'(vec_tvalid), wide_t'(1));
    check("hold_overrun", wide_t'(overrun), wide_t'(1));
    check("hold_sum", wide_t'(vec_sum), wide_t'(182));
    check("hold_data", vec_tdata, pack(fr));
    @(posedge clk); #1 vec_tready = 1'b1;
    wait_drain();

    // start coincident with an element: element dropped, overrun set, frame unaffected.
    @(posedge clk); #1 start = 1'b1; backbone_J_tvalid = 1'b1; backbone_J = 32'd77;
    @(posedge clk); #1 start = 1'b0; backbone_J_tvalid = 1'b0; backbone_J = '0;
    @(negedge clk);
    check("coinc_overrun", wide_t'(overrun), wide_t'(1));
    check("coinc_tvalid", wide_t'(vec_tvalid), wide_t'(0));
    for (int k = 0; k < N; k++) fr[k] = 32'(10 * (k + 1));
    push_frame(fr, 36'd910, 32'd130, 5'd12);
    send_frame(fr);
    wait_drain();
    check("overrun_sticky", wide_t'(overrun), wide_t'(1));

    // Asynchronous reset mid-frame after 6 elements.
    @(posedge clk); #1 start = 1'b1; backbone_J_tvalid = 1'b1; backbone_J = 32'd5;
    @(posedge clk); #1 start = 1'b0; backbone_J_tvalid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1 backbone_J_tvalid = 1'b1; backbone_J = 32'(k + 1);
    end
    @(posedge clk); #1 backbone_J_tvalid = 1'b0; backbone_J = '0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_tvalid", wide_t'(vec_tvalid), wide_t'(0));
    check("arst_tdata", vec_tdata, wide_t'(0));
    check("arst_sum", wide_t'(vec_sum), wide_t'(0));
    check("arst_overrun", wide_t'(overrun), wide_t'(0));
    check("arst_max", wide_t'(vec_max), wide_t'(0));
    check("arst_argmax", wide_t'(vec_argmax), wide_t'(0));
    @(posedge clk); #1 rst_n = 1'b1;

    for (int k = 0; k < N; k++) fr[k] = 32'(100 + k);
    do_start();
    push_frame(fr, 36'd1378, 32'd112, 5'd12);
    send_frame(fr);
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
